pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register that generalises the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block.
- Carries an arbitrary-width data payload plus a control-bit bundle, with a valid/ready handshake.
- Provides synchronous flush (branch/exception squash) and bubble semantics: control bits read zero whenever the stage is empty.
- An optional skid entry gives full throughput with a registered upstream ready.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline boundary register.
//   stage_state_e : occupancy state of a skid-buffered stage
//   OCC_W         : width of the occupancy count (0..2)
//   *_DEF         : default payload/control widths of a classic RISC stage
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned OCC_W         = 2;
  localparam int unsigned CTRL_W_DEF    = 12;
  localparam int unsigned PAYLOAD_W_DEF = 143;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: valid bit plus payload/control.
//   clk, reset      : clock, asynchronous active-high reset (clears everything)
//   load            : capture d_payload/d_ctrl and mark valid
//   clear           : drop the entry (wins over load); data left as-is
//   valid, q_*      : stored entry
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 clear,
  input  logic [PAYLOAD_W-1:0] d_payload,
  input  logic [CTRL_W-1:0]    d_ctrl,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] q_payload,
  output logic [CTRL_W-1:0]    q_ctrl
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= 1'b0;
      q_payload <= '0;
      q_ctrl    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      q_payload <= d_payload;
      q_ctrl    <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with valid/ready handshake, flush and
// bubble suppression of the control bundle.
//   clk, reset             : clock, asynchronous active-high reset
//   flush                  : synchronous squash of all held entries
//   in_valid/in_ready      : upstream handshake, in_payload/in_ctrl sampled on accept
//   out_valid/out_ready    : downstream handshake
//   out_payload/out_ctrl   : head entry; out_ctrl is zero while the stage is empty
//   occupancy              : number of entries held
// SKID=1 adds a second entry so in_ready can come straight from a register;
// SKID=0 is a single entry whose in_ready depends combinationally on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned SKID      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [OCC_W-1:0]     occupancy
);

  logic                 accept;
  logic                 main_valid;
  logic                 main_load;
  logic                 main_clear;
  logic [PAYLOAD_W-1:0] main_d_payload;
  logic [CTRL_W-1:0]    main_d_ctrl;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [CTRL_W-1:0]    main_ctrl;
  logic                 skid_valid;

  assign accept = in_valid & in_ready;

  pipe_slot #(
    .PAYLOAD_W (PAYLOAD_W),
    .CTRL_W    (CTRL_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .d_payload (main_d_payload),
    .d_ctrl    (main_d_ctrl),
    .valid     (main_valid),
    .q_payload (main_payload),
    .q_ctrl    (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e         state_q;
      stage_state_e         state_d;
      logic                 skid_load;
      logic                 skid_clear;
      logic                 main_from_skid;
      logic [PAYLOAD_W-1:0] skid_payload;
      logic [CTRL_W-1:0]    skid_ctrl;

      pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_W    (CTRL_W)
      ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .d_payload (in_payload),
        .d_ctrl    (in_ctrl),
        .valid     (skid_valid),
        .q_payload (skid_payload),
        .q_ctrl    (skid_ctrl)
      );

      always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
      end

      // The state mirrors the slot valid bits; it only steers loads/clears.
      // In ONE and FULL the main slot is valid, so out_ready alone means transfer.
      always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                main_load = 1'b1;
                state_d   = ONE;
              end
            end
            ONE: begin
              if (accept && out_ready) begin
                main_load = 1'b1;
              end else if (out_ready) begin
                main_clear = 1'b1;
                state_d    = EMPTY;
              end else if (accept) begin
                skid_load = 1'b1;
                state_d   = FULL;
              end
            end
            FULL: begin
              if (out_ready) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clear     = 1'b1;
                state_d        = ONE;
              end
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      assign main_d_payload = main_from_skid ? skid_payload : in_payload;
      assign main_d_ctrl    = main_from_skid ? skid_ctrl    : in_ctrl;
      assign in_ready       = (state_q != FULL);
    end else begin : g_single
      logic xfer;

      assign xfer           = main_valid & out_ready;
      assign skid_valid     = 1'b0;
      assign in_ready       = ~main_valid | out_ready;
      assign main_load      = accept & ~flush;
      assign main_clear     = flush | (xfer & ~accept);
      assign main_d_payload = in_payload;
      assign main_d_ctrl    = in_ctrl;
    end
  endgenerate

  assign out_valid   = main_valid;
  assign out_payload = main_payload;
  assign out_ctrl    = main_valid ? main_ctrl : '0;
  assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int unsigned PW = 143;
  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] in_payload, out_payload;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;

  logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [PW-1:0] s0_in_payload, s0_out_payload;
  logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
  logic [1:0]    s0_occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_payload(s0_in_payload), .in_ctrl(s0_in_ctrl),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_payload(s0_out_payload),
    .out_ctrl(s0_out_ctrl), .occupancy(s0_occupancy)
  );

  typedef struct {
    logic        iv, rdy, fl;
    logic [15:0] pay;
    logic [11:0] ctrl;
    logic        eov;
    logic [15:0] epay;
    logic [11:0] ectrl;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  function automatic vec_t mk(input logic iv, input logic rdy, input logic fl,
                              input logic [15:0] pay, input logic [11:0] ctrl,
                              input logic eov, input logic [15:0] epay,
                              input logic [11:0] ectrl, input logic [1:0] eocc,
                              input logic erdy);
    vec_t v;
    v.iv = iv; v.rdy = rdy; v.fl = fl; v.pay = pay; v.ctrl = ctrl;
    v.eov = eov; v.epay = epay; v.ectrl = ectrl; v.eocc = eocc; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Bubble: control held at all-ones on the input while nothing is valid
    tv[0]  = mk(0,1,0,16'h0000,12'hFFF, 0,16'h0000,12'h000,2'd0,1);
    tv[1]  = mk(0,0,0,16'h0000,12'hFFF, 0,16'h0000,12'h000,2'd0,1);
    // Streaming 1..8 at full rate
    for (int k = 1; k <= 8; k++)
      tv[k+1] = mk(1,1,0,16'(k),12'hA00 + 12'(k), 1,16'(k),12'hA00 + 12'(k),2'd1,1);
    tv[10] = mk(0,1,0,16'h0000,12'hFFF, 0,16'h0000,12'h000,2'd0,1);
    // Backpressure: 0x11..0x14, out_ready low for two cycles
    tv[11] = mk(1,1,0,16'h0011,12'hB11, 1,16'h0011,12'hB11,2'd1,1);
    tv[12] = mk(1,0,0,16'h0012,12'hB12, 1,16'h0011,12'hB11,2'd2,0);
    tv[13] = mk(1,0,0,16'h0013,12'hB13, 1,16'h0011,12'hB11,2'd2,0);
    tv[14] = mk(1,1,0,16'h0013,12'hB13, 1,16'h0012,12'hB12,2'd1,1);
    tv[15] = mk(1,1,0,16'h0013,12'hB13, 1,16'h0013,12'hB13,2'd1,1);
    tv[16] = mk(1,1,0,16'h0014,12'hB14, 1,16'h0014,12'hB14,2'd1,1);
    tv[17] = mk(0,1,0,16'h0000,12'h000, 0,16'h0000,12'h000,2'd0,1);
    // Flush in FULL while 0x77 is offered
    tv[18] = mk(1,0,0,16'h0021,12'hC21, 1,16'h0021,12'hC21,2'd1,1);
    tv[19] = mk(1,0,0,16'h0022,12'hC22, 1,16'h0021,12'hC21,2'd2,0);
    tv[20] = mk(1,0,1,16'h0077,12'hF77, 0,16'h0000,12'h000,2'd0,1);
    tv[21] = mk(0,1,0,16'h0000,12'hFFF, 0,16'h0000,12'h000,2'd0,1);
    // Flush in ONE drops a same-cycle accept
    tv[22] = mk(1,1,0,16'h0031,12'hD31, 1,16'h0031,12'hD31,2'd1,1);
    tv[23] = mk(1,1,1,16'h0032,12'hD32, 0,16'h0000,12'h000,2'd0,1);
    tv[24] = mk(0,1,0,16'h0000,12'h000, 0,16'h0000,12'h000,2'd0,1);
    // ONE with neither side moving holds its entry
    tv[25] = mk(1,1,0,16'h0041,12'hE41, 1,16'h0041,12'hE41,2'd1,1);
    tv[26] = mk(0,0,0,16'h0000,12'hFFF, 1,16'h0041,12'hE41,2'd1,1);
    tv[27] = mk(0,1,0,16'h0000,12'hFFF, 0,16'h0000,12'h000,2'd0,1);

    reset = 1'b1; flush = 0; in_valid = 0; out_ready = 0; in_payload = '0; in_ctrl = '0;
    s0_flush = 0; s0_in_valid = 0; s0_out_ready = 0; s0_in_payload = '0; s0_in_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_pay", out_payload, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_irdy", in_ready, 1);
    chk("rst0_ov", s0_out_valid, 0);
    chk("rst0_occ", s0_occupancy, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      in_valid   = tv[i].iv;
      out_ready  = tv[i].rdy;
      flush      = tv[i].fl;
      in_payload = '0;
      in_payload[15:0] = tv[i].pay;
      in_ctrl    = tv[i].ctrl;
      step();
      chk($sformatf("v%0d_ov", i), out_valid, tv[i].eov);
      chk($sformatf("v%0d_ctrl", i), out_ctrl, tv[i].ectrl);
      chk($sformatf("v%0d_occ", i), occupancy, tv[i].eocc);
      chk($sformatf("v%0d_irdy", i), in_ready, tv[i].erdy);
      if (tv[i].eov)
        chk($sformatf("v%0d_pay", i), out_payload, tv[i].epay);
    end
    flush = 0;

    // Asynchronous reset with two entries held
    in_valid = 1; out_ready = 0;
    in_payload = '0; in_payload[15:0] = 16'h0051; in_ctrl = 12'h151;
    step();
    chk("mr_occ1", occupancy, 1);
    in_payload[15:0] = 16'h0052; in_ctrl = 12'h152;
    step();
    chk("mr_occ2", occupancy, 2);
    chk("mr_irdy_full", in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_ctrl", out_ctrl, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_irdy", in_ready, 1);
    chk("mr_pay", out_payload, 0);
    @(negedge clk);
    in_payload = '0; in_payload[15:0] = 16'hA5A5; in_ctrl = 12'h5A5;
    in_valid = 1; out_ready = 1;
    reset = 1'b0;
    step();
    chk("pr_ov", out_valid, 1);
    chk("pr_pay", out_payload, 16'hA5A5);
    chk("pr_ctrl", out_ctrl, 12'h5A5);
    chk("pr_occ", occupancy, 1);
    in_valid = 0;
    step();
    chk("pr_drain", out_valid, 0);

    // Single-entry build
    s0_in_valid = 1; s0_out_ready = 0;
    s0_in_payload = '0; s0_in_payload[15:0] = 16'h0005; s0_in_ctrl = 12'h305;
    #1;
    chk("s0_irdy_empty", s0_in_ready, 1);
    step();
    chk("s0_ov1", s0_out_valid, 1);
    chk("s0_pay1", s0_out_payload, 16'h0005);
    chk("s0_ctrl1", s0_out_ctrl, 12'h305);
    chk("s0_occ1", s0_occupancy, 1);
    chk("s0_irdy_full", s0_in_ready, 0);
    s0_out_ready = 1; s0_in_payload[15:0] = 16'h0006; s0_in_ctrl = 12'h306;
    #1;
    chk("s0_irdy_comb", s0_in_ready, 1);
    step();
    chk("s0_ov2", s0_out_valid, 1);
    chk("s0_pay2", s0_out_payload, 16'h0006);
    chk("s0_occ2", s0_occupancy, 1);
    s0_in_valid = 0;
    step();
    chk("s0_ov3", s0_out_valid, 0);
    chk("s0_ctrl3", s0_out_ctrl, 0);
    chk("s0_occ3", s0_occupancy, 0);
    s0_in_valid = 1; s0_out_ready = 0; s0_in_payload[15:0] = 16'h0007; s0_in_ctrl = 12'h307;
    step();
    chk("s0_occ4", s0_occupancy, 1);
    s0_flush = 1; s0_out_ready = 1; s0_in_payload[15:0] = 16'h0008; s0_in_ctrl = 12'h308;
    step();
    chk("s0_fl_ov", s0_out_valid, 0);
    chk("s0_fl_ctrl", s0_out_ctrl, 0);
    chk("s0_fl_occ", s0_occupancy, 0);
    s0_flush = 0; s0_in_valid = 0;
    step();
    chk("s0_fl_after", s0_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
